// File: rtl/turn_scheduler.sv
// turn_scheduler
// Turn sequencer for the Generals game logic. Picks whose turn it is, runs
// the per-turn countdown, skips eliminated players, counts rounds and
// declares the winner once at most one player is left.
//
// Ports:
//   clock           game-logic clock
//   reset           asynchronous, active-high reset
//   start           level, sampled only while idle; begins a game
//   alive_mask      bit i-1 set = player i still owns a crown
//   move_done       one-cycle pulse, current player committed a move
//   current_player  player whose turn it is (0 when not playing)
//   next_player     player after current (0 outside a running turn)
//   step_time_left  seconds left in the current turn
//   round           round number, 1 for the first round, saturating
//   turn_start      one-cycle pulse on every new turn
//   turn_timeout    one-cycle pulse when a turn expires unplayed
//   round_end       one-cycle pulse when play wraps to a lower-or-equal index
//   game_over       level, set once at most one player is alive
//   winner          sole survivor latched at game end, 0 if none
//   state_dbg       current FSM state (IDLE=0, TURN=1, ADVANCE=2, OVER=3)
//
// Interaction with move_done: it is only looked at while a turn is running.
// A move in the same cycle as the final countdown wrap wins over the expiry,
// so no timeout pulse is produced for that turn.
module turn_scheduler #(
  parameter int MAX_PLAYER_CNT      = 7,
  parameter int LOG2_MAX_PLAYER_CNT = 3,
  parameter int MAX_STEP_TIME       = 15,
  parameter int LOG2_MAX_STEP_TIME  = 4,
  parameter int LOG2_MAX_ROUND      = 12,
  parameter int TICKS_PER_SEC       = 50_000_000
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [MAX_PLAYER_CNT-1:0]      alive_mask,
  input  logic                           move_done,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] current_player,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] next_player,
  output logic [LOG2_MAX_STEP_TIME-1:0]  step_time_left,
  output logic [LOG2_MAX_ROUND-1:0]      round,
  output logic                           turn_start,
  output logic                           turn_timeout,
  output logic                           round_end,
  output logic                           game_over,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] winner,
  output logic [1:0]                     state_dbg
);

  localparam int PW     = LOG2_MAX_PLAYER_CNT;
  localparam int SW     = LOG2_MAX_STEP_TIME;
  localparam int RW     = LOG2_MAX_ROUND;
  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [SW-1:0]     STEP_FULL   = SW'(MAX_STEP_TIME);
  localparam logic [SW-1:0]     STEP_ONE    = SW'(1);
  localparam logic [PW-1:0]     LAST_PLAYER = PW'(MAX_PLAYER_CNT);
  localparam logic [RW-1:0]     ROUND_FIRST = RW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TURN    = 2'd1,
    ADVANCE = 2'd2,
    OVER    = 2'd3
  } state_t;

  // First alive player after p, scanning 1..MAX_PLAYER_CNT cyclically with p
  // itself examined last. Called with p = MAX_PLAYER_CNT it returns the
  // lowest alive player. Returns 0 when nobody is alive.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0]             p,
                                        input logic [MAX_PLAYER_CNT-1:0] mask);
    logic [PW-1:0]             r;
    logic                      found;
    logic [MAX_PLAYER_CNT-1:0] mask_s;
    int                        idx;
    r     = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_PLAYER_CNT; k++) begin
      idx = int'(p) + k;
      if (idx > MAX_PLAYER_CNT) idx = idx - MAX_PLAYER_CNT;
      mask_s = mask >> (idx - 1);
      if (!found && mask_s[0]) begin
        r     = PW'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic int popcount(input logic [MAX_PLAYER_CNT-1:0] mask);
    int c;
    c = 0;
    for (int i = 0; i < MAX_PLAYER_CNT; i++) begin
      if (mask[i]) c = c + 1;
    end
    return c;
  endfunction

  state_t              state_q, state_d;
  logic [PW-1:0]       cur_q, cur_d;
  logic [PW-1:0]       next_q, next_d;
  logic [SW-1:0]       step_q, step_d;
  logic [RW-1:0]       round_q, round_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                turn_start_q, turn_start_d;
  logic                timeout_q, timeout_d;
  logic                round_end_q, round_end_d;
  logic                game_over_q, game_over_d;
  logic [PW-1:0]       winner_q, winner_d;

  int                  alive_cnt;
  logic                cur_alive;
  logic                wrap;
  logic [PW-1:0]       adv_player;

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    step_d       = step_q;
    round_d      = round_q;
    tick_d       = tick_q;
    turn_start_d = 1'b0;
    timeout_d    = 1'b0;
    round_end_d  = 1'b0;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    next_d       = '0;

    alive_cnt  = popcount(alive_mask);
    adv_player = nxt(cur_q, alive_mask);
    wrap       = (tick_q == TICK_LAST);

    cur_alive = 1'b0;
    for (int i = 0; i < MAX_PLAYER_CNT; i++) begin
      if (cur_q == PW'(i + 1)) cur_alive = alive_mask[i];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (alive_cnt >= 2) begin
            state_d      = TURN;
            cur_d        = nxt(LAST_PLAYER, alive_mask);
            round_d      = ROUND_FIRST;
            step_d       = STEP_FULL;
            tick_d       = '0;
            turn_start_d = 1'b1;
          end else begin
            state_d     = OVER;
            game_over_d = 1'b1;
            winner_d    = nxt(LAST_PLAYER, alive_mask);
            cur_d       = '0;
          end
        end
      end

      TURN: begin
        // The countdown keeps running in the cycle that leaves TURN, so a
        // move landing on the last wrap still shows zero seconds left.
        if (wrap) begin
          tick_d = '0;
          step_d = step_q - 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
        if (move_done || !cur_alive) begin
          state_d = ADVANCE;
        end else if (wrap && (step_q == STEP_ONE)) begin
          state_d   = ADVANCE;
          timeout_d = 1'b1;
        end
      end

      ADVANCE: begin
        if (alive_cnt <= 1) begin
          state_d     = OVER;
          game_over_d = 1'b1;
          winner_d    = nxt(LAST_PLAYER, alive_mask);
          cur_d       = '0;
        end else begin
          state_d      = TURN;
          cur_d        = adv_player;
          // Wrapping to a lower-or-equal index closes the round.
          if (adv_player <= cur_q) begin
            round_end_d = 1'b1;
            if (round_q != '1) round_d = round_q + 1'b1;
          end
          step_d       = STEP_FULL;
          tick_d       = '0;
          turn_start_d = 1'b1;
        end
      end

      default: begin
        // OVER: everything frozen until reset.
        cur_d = '0;
      end
    endcase

    if (state_d == TURN) next_d = nxt(cur_d, alive_mask);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      next_q       <= '0;
      step_q       <= '0;
      round_q      <= '0;
      tick_q       <= '0;
      turn_start_q <= 1'b0;
      timeout_q    <= 1'b0;
      round_end_q  <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      next_q       <= next_d;
      step_q       <= step_d;
      round_q      <= round_d;
      tick_q       <= tick_d;
      turn_start_q <= turn_start_d;
      timeout_q    <= timeout_d;
      round_end_q  <= round_end_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
    end
  end

  assign current_player = cur_q;
  assign next_player    = next_q;
  assign step_time_left = step_q;
  assign round          = round_q;
  assign turn_start     = turn_start_q;
  assign turn_timeout   = timeout_q;
  assign round_end      = round_end_q;
  assign game_over      = game_over_q;
  assign winner         = winner_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Bench for turn_scheduler with 4 players, 4 ticks per second and 3 seconds
// per turn. A behavioural model tracks elapsed cycles per turn and derives
// the countdown arithmetically; a compare process checks every output on
// every falling edge, and directed steps pin key values with literals.
module tb_turn_scheduler;

  localparam int N     = 4;
  localparam int PW    = 3;
  localparam int STEP  = 3;
  localparam int SW    = 2;
  localparam int RW    = 12;
  localparam int TICKS = 4;

  logic          clock;
  logic          reset;
  logic          start;
  logic [N-1:0]  alive_mask;
  logic          move_done;
  logic [PW-1:0] current_player;
  logic [PW-1:0] next_player;
  logic [SW-1:0] step_time_left;
  logic [RW-1:0] round;
  logic          turn_start;
  logic          turn_timeout;
  logic          round_end;
  logic          game_over;
  logic [PW-1:0] winner;
  logic [1:0]    state_dbg;

  turn_scheduler #(
    .MAX_PLAYER_CNT(N), .LOG2_MAX_PLAYER_CNT(PW), .MAX_STEP_TIME(STEP),
    .LOG2_MAX_STEP_TIME(SW), .LOG2_MAX_ROUND(RW), .TICKS_PER_SEC(TICKS)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .alive_mask(alive_mask),
    .move_done(move_done), .current_player(current_player),
    .next_player(next_player), .step_time_left(step_time_left),
    .round(round), .turn_start(turn_start), .turn_timeout(turn_timeout),
    .round_end(round_end), .game_over(game_over), .winner(winner),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- counters / check task ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int lowest(input logic [N-1:0] a);
    for (int i = 0; i < N; i++) if (a[i]) return i + 1;
    return 0;
  endfunction

  function automatic int nxt_m(input int p, input logic [N-1:0] a);
    int q;
    for (int k = 1; k <= N; k++) begin
      q = ((p + k - 1) % N) + 1;
      if (a[q-1]) return q;
    end
    return 0;
  endfunction

  function automatic int popc(input logic [N-1:0] a);
    int c = 0;
    for (int i = 0; i < N; i++) if (a[i]) c++;
    return c;
  endfunction

  bit m_playing, m_adv, m_over, m_ts, m_to, m_re;
  int m_cur, m_next, m_win, m_e, m_round, m_step;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_playing = 0; m_adv = 0; m_over = 0;
      m_ts = 0; m_to = 0; m_re = 0;
      m_cur = 0; m_next = 0; m_win = 0; m_e = 0; m_round = 0; m_step = 0;
    end else begin
      int n;
      m_ts = 0; m_to = 0; m_re = 0;
      if (m_over) begin
        // frozen
      end else if (!m_playing) begin
        if (start) begin
          if (popc(alive_mask) >= 2) begin
            m_playing = 1; m_adv = 0;
            m_cur = lowest(alive_mask); m_round = 1; m_e = 0; m_ts = 1;
          end else begin
            m_over = 1; m_win = lowest(alive_mask);
          end
        end
      end else if (!m_adv) begin
        m_e++;
        if (move_done || !alive_mask[m_cur-1]) m_adv = 1;
        else if (m_e == STEP * TICKS) begin m_adv = 1; m_to = 1; end
      end else begin
        if (popc(alive_mask) <= 1) begin
          m_over = 1; m_playing = 0; m_win = lowest(alive_mask); m_cur = 0;
        end else begin
          n = nxt_m(m_cur, alive_mask);
          if (n <= m_cur) begin
            if (m_round < 4095) m_round++;
            m_re = 1;
          end
          m_cur = n; m_e = 0; m_ts = 1; m_adv = 0;
        end
      end
      if (m_playing) m_step = STEP - m_e / TICKS;
      m_next = (m_playing && !m_adv) ? nxt_m(m_cur, alive_mask) : 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    chk("current_player", current_player, m_cur);
    chk("next_player",    next_player,    m_next);
    chk("step_time_left", step_time_left, m_step);
    chk("round",          round,          m_round);
    chk("turn_start",     turn_start,     m_ts);
    chk("turn_timeout",   turn_timeout,   m_to);
    chk("round_end",      round_end,      m_re);
    chk("game_over",      game_over,      m_over);
    chk("winner",         winner,         m_win);
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Pulse move_done for one cycle and return at the falling edge after the
  // ADVANCE cycle, where the next turn is visible.
  task automatic pulse_move();
    move_done = 1'b1;
    @(negedge clock);
    move_done = 1'b0;
    @(negedge clock);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; start = 1'b0; alive_mask = '0; move_done = 1'b0;
    cycles(2);
    chk("rst_cur", current_player, 0);
    chk("rst_step", step_time_left, 0);
    chk("rst_round", round, 0);
    chk("rst_state", state_dbg, 0);
    chk("rst_game_over", game_over, 0);
    reset = 1'b0;

    // move_done while idle is ignored
    alive_mask = 4'b1111; move_done = 1'b1;
    cycles(1);
    move_done = 1'b0;
    chk("idle_move_state", state_dbg, 0);

    // start with everyone alive
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    chk("s1_cur", current_player, 1);
    chk("s1_next", next_player, 2);
    chk("s1_round", round, 1);
    chk("s1_step", step_time_left, 3);
    chk("s1_ts", turn_start, 1);
    chk("s1_state", state_dbg, 1);
    cycles(1);
    chk("s1_ts_low", turn_start, 0);

    // play through players 2,3,4 then wrap to 1
    pulse_move(); pulse_move(); pulse_move();
    chk("p4_cur", current_player, 4);
    chk("p4_next", next_player, 1);
    pulse_move();
    chk("wrap_cur", current_player, 1);
    chk("wrap_round", round, 2);
    chk("wrap_re", round_end, 1);
    chk("wrap_ts", turn_start, 1);

    // unplayed turn: countdown and timeout
    cycles(1);
    chk("wrap_re_low", round_end, 0);
    cycles(2);
    chk("cd_step3", step_time_left, 3);
    cycles(1);
    chk("cd_step2", step_time_left, 2);
    cycles(4);
    chk("cd_step1", step_time_left, 1);
    cycles(4);
    chk("cd_step0", step_time_left, 0);
    chk("cd_timeout", turn_timeout, 1);
    chk("cd_cur_hold", current_player, 1);
    cycles(1);
    chk("cd_timeout_low", turn_timeout, 0);
    chk("cd_cur2", current_player, 2);
    chk("cd_ts", turn_start, 1);

    // move coinciding with the final wrap: no timeout
    cycles(11);
    move_done = 1'b1;
    cycles(1);
    move_done = 1'b0;
    chk("late_to", turn_timeout, 0);
    chk("late_step", step_time_left, 0);
    cycles(1);
    chk("late_cur", current_player, 3);
    chk("late_ts", turn_start, 1);

    // reach player 2 in round 3
    pulse_move(); pulse_move(); pulse_move();
    chk("r3_cur", current_player, 2);
    chk("r3_round", round, 3);

    // player 3 dead: skipped
    alive_mask = 4'b1011;
    pulse_move();
    chk("skip_cur", current_player, 4);
    chk("skip_next", next_player, 1);

    // player 4 eliminated mid-turn
    alive_mask = 4'b0011;
    cycles(1);
    chk("elim_to", turn_timeout, 0);
    chk("elim_state", state_dbg, 2);
    cycles(1);
    chk("elim_cur", current_player, 1);
    chk("elim_re", round_end, 1);
    chk("elim_round", round, 4);

    // get to player 3, then leave only player 3 alive
    alive_mask = 4'b0111;
    pulse_move(); pulse_move();
    chk("g_cur3", current_player, 3);
    alive_mask = 4'b0100; move_done = 1'b1;
    cycles(1);
    move_done = 1'b0;
    cycles(1);
    chk("over_go", game_over, 1);
    chk("over_win", winner, 3);
    chk("over_cur", current_player, 0);
    chk("over_next", next_player, 0);
    chk("over_state", state_dbg, 3);

    // OVER ignores start, move_done and alive changes
    start = 1'b1; move_done = 1'b1; alive_mask = 4'b1111;
    cycles(3);
    start = 1'b0; move_done = 1'b0;
    chk("frozen_go", game_over, 1);
    chk("frozen_win", winner, 3);
    chk("frozen_cur", current_player, 0);

    // start with nobody alive
    reset = 1'b1;
    cycles(1);
    reset = 1'b0; alive_mask = 4'b0000; start = 1'b1;
    cycles(1);
    start = 1'b0;
    chk("none_go", game_over, 1);
    chk("none_win", winner, 0);
    chk("none_state", state_dbg, 3);

    // reset in the middle of a countdown
    reset = 1'b1;
    cycles(1);
    reset = 1'b0; alive_mask = 4'b1111; start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(5);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_cur", current_player, 0);
    chk("mid_rst_next", next_player, 0);
    chk("mid_rst_step", step_time_left, 0);
    chk("mid_rst_round", round, 0);
    chk("mid_rst_state", state_dbg, 0);
    cycles(1);
    reset = 1'b0;
    cycles(1);
    chk("post_rst_ts", turn_start, 0);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    chk("re_cur", current_player, 1);
    chk("re_next", next_player, 2);
    chk("re_round", round, 1);
    chk("re_step", step_time_left, 3);
    chk("re_ts", turn_start, 1);
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
